// File: rtl/regdst_pkg.sv
// Shared constants for the register-destination tracking pipeline:
// architectural register numbers and destination-select slot encodings.
package regdst_pkg;

    localparam int DEF_ADDR_W = 5;

    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 29;
    localparam int REG_RA   = 31;

    // Slots 2 and 3 are hard-wired; slots 0, 1 and 4+ come from the source bus.
    localparam int SEL_RT = 0;
    localparam int SEL_RD = 1;
    localparam int SEL_SP = 2;
    localparam int SEL_RA = 3;

endpackage

// File: rtl/regdst_stage.sv
// One {valid, dest} tracking register. Bubble beats hold, hold beats load.
module regdst_stage
    import regdst_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rstN,
    input  logic              i_hold,
    input  logic              i_bubble,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_dest,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_dest
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_dest;

    always_ff @(posedge i_clk) begin
        if (!i_rstN) begin
            r_valid <= 1'b0;
            r_dest  <= '0;
        end else if (i_bubble) begin
            r_valid <= 1'b0;
            r_dest  <= '0;
        end else if (!i_hold) begin
            r_valid <= i_valid;
            r_dest  <= i_dest;
        end
    end

    assign o_valid = r_valid;
    assign o_dest  = r_dest;

endmodule

// File: rtl/regdst_pipe.sv
// Destination-register selector with an in-flight tracking pipeline that
// reports read-after-write hazards for two source operands.
module regdst_pipe
    import regdst_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int SEL_W  = 3,
    parameter int STAGES = 3,
    parameter int CONST2 = REG_SP,
    parameter int CONST3 = REG_RA
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          issue_valid,
    input  logic                          wr_en,
    input  logic [SEL_W-1:0]              sel,
    input  logic [(2**SEL_W)*ADDR_W-1:0]  src_bus,
    input  logic                          stall,
    input  logic                          flush,
    input  logic [ADDR_W-1:0]             rs_addr,
    input  logic [ADDR_W-1:0]             rt_addr,
    output logic [ADDR_W-1:0]             dest_sel,
    output logic                          hazard_rs,
    output logic                          hazard_rt,
    output logic                          wb_valid,
    output logic [ADDR_W-1:0]             wb_dest
);

    logic [ADDR_W-1:0] w_destSel;
    logic              w_entryValid;

    logic [STAGES-1:0] w_stgValid;
    logic [ADDR_W-1:0] w_stgDest [STAGES];
    logic [STAGES-1:0] w_inValid;
    logic [ADDR_W-1:0] w_inDest  [STAGES];
    logic [STAGES-1:0] w_hold;
    logic [STAGES-1:0] w_bubble;

    logic w_hitRs;
    logic w_hitRt;

    always_comb begin
        case (int'(sel))
            SEL_SP:  w_destSel = ADDR_W'(CONST2);
            SEL_RA:  w_destSel = ADDR_W'(CONST3);
            default: w_destSel = src_bus[int'(sel)*ADDR_W +: ADDR_W];
        endcase
    end

    // $zero is never tracked, so it can neither hazard nor write back.
    assign w_entryValid = issue_valid & wr_en & (w_destSel != ADDR_W'(REG_ZERO));
    assign dest_sel     = w_destSel;

    // A stall freezes stage 1 and feeds a bubble into stage 2 so that older
    // entries keep draining; flush overrides the stall and empties stage 1.
    always_comb begin
        w_inValid[0] = w_entryValid;
        w_inDest[0]  = w_destSel;
        w_hold[0]    = stall;
        w_bubble[0]  = flush;
        for (int i = 1; i < STAGES; i++) begin
            w_inValid[i] = w_stgValid[i-1];
            w_inDest[i]  = w_stgDest[i-1];
            w_hold[i]    = 1'b0;
            w_bubble[i]  = (i == 1) ? (stall & ~flush) : 1'b0;
        end
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        regdst_stage #(
            .ADDR_W (ADDR_W)
        ) u_stage (
            .i_clk    (clk),
            .i_rstN   (reset),
            .i_hold   (w_hold[gi]),
            .i_bubble (w_bubble[gi]),
            .i_valid  (w_inValid[gi]),
            .i_dest   (w_inDest[gi]),
            .o_valid  (w_stgValid[gi]),
            .o_dest   (w_stgDest[gi])
        );
    end

    // The writeback stage is included: no same-cycle write/read bypass exists.
    always_comb begin
        w_hitRs = 1'b0;
        w_hitRt = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            if (w_stgValid[i] && (w_stgDest[i] == rs_addr)) w_hitRs = 1'b1;
            if (w_stgValid[i] && (w_stgDest[i] == rt_addr)) w_hitRt = 1'b1;
        end
    end

    assign hazard_rs = w_hitRs & (rs_addr != ADDR_W'(REG_ZERO));
    assign hazard_rt = w_hitRt & (rt_addr != ADDR_W'(REG_ZERO));

    assign wb_valid = w_stgValid[STAGES-1];
    assign wb_dest  = w_stgDest[STAGES-1];

endmodule

// File: tb/tb_regdst_pipe.sv
// Scoreboard bench for regdst_pipe: directed scenarios followed by random
// traffic, checked against a list-of-in-flight-entries reference model.
module tb_regdst_pipe;
    import regdst_pkg::*;

    localparam int ADDR_W = 5;
    localparam int SEL_W  = 3;
    localparam int NSEL   = 8;
    localparam int STAGES = 3;
    localparam int CONST2 = 29;
    localparam int CONST3 = 31;

    logic                     clk = 1'b0;
    logic                     rstN;
    logic                     issueValid;
    logic                     wrEn;
    logic [SEL_W-1:0]         selIn;
    logic [NSEL*ADDR_W-1:0]   srcBus;
    logic                     stallIn;
    logic                     flushIn;
    logic [ADDR_W-1:0]        rsAddr;
    logic [ADDR_W-1:0]        rtAddr;
    logic [ADDR_W-1:0]        destSel;
    logic                     hazardRs;
    logic                     hazardRt;
    logic                     wbValid;
    logic [ADDR_W-1:0]        wbDest;

    always #5 clk = ~clk;

    regdst_pipe #(
        .ADDR_W (ADDR_W),
        .SEL_W  (SEL_W),
        .STAGES (STAGES),
        .CONST2 (CONST2),
        .CONST3 (CONST3)
    ) dut (
        .clk         (clk),
        .reset       (rstN),
        .issue_valid (issueValid),
        .wr_en       (wrEn),
        .sel         (selIn),
        .src_bus     (srcBus),
        .stall       (stallIn),
        .flush       (flushIn),
        .rs_addr     (rsAddr),
        .rt_addr     (rtAddr),
        .dest_sel    (destSel),
        .hazard_rs   (hazardRs),
        .hazard_rt   (hazardRt),
        .wb_valid    (wbValid),
        .wb_dest     (wbDest)
    );

    typedef struct {
        int dest;
        int pos;
    } ent_t;

    ent_t ents[$];
    int   expQ[$];
    int   slot[NSEL];
    int   total = 0;
    int   bad   = 0;
    bit   monitorOn = 1'b0;

    function automatic int refSel(input int s);
        if (s == 2) return CONST2;
        if (s == 3) return CONST3;
        return slot[s];
    endfunction

    function automatic bit refHaz(input int a);
        if (a == 0) return 1'b0;
        foreach (ents[i]) if (ents[i].dest == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit refWbValid();
        foreach (ents[i]) if (ents[i].pos == STAGES) return 1'b1;
        return 1'b0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit rn, input bit iv, input bit we, input bit st, input bit fl,
                                 input int s, input int rs, input int rt);
        rstN       = rn;
        issueValid = iv;
        wrEn       = we;
        stallIn    = st;
        flushIn    = fl;
        selIn      = SEL_W'(s);
        rsAddr     = ADDR_W'(rs);
        rtAddr     = ADDR_W'(rt);
        for (int k = 0; k < NSEL; k++) srcBus[k*ADDR_W +: ADDR_W] = ADDR_W'(slot[k]);
    endtask

    // Advance the reference model across one clock edge using the applied inputs.
    task automatic modelStep();
        ent_t nxt[$];
        ent_t e;
        int   d;
        if (!rstN) begin
            ents.delete();
            expQ.delete();
            return;
        end
        foreach (ents[i]) begin
            e = ents[i];
            if (e.pos == 1) begin
                if (!(stallIn && !flushIn)) e.pos = 2;
            end else begin
                e.pos++;
            end
            if (e.pos <= STAGES) nxt.push_back(e);
        end
        d = refSel(int'(selIn));
        if (!flushIn && !stallIn && issueValid && wrEn && d != 0) begin
            e.dest = d;
            e.pos  = 1;
            nxt.push_back(e);
            expQ.push_back(d);
        end
        ents = nxt;
    endtask

    task automatic stepCycle(input bit rn, input bit iv, input bit we, input bit st, input bit fl,
                             input int s, input int rs, input int rt);
        applyStimulus(rn, iv, we, st, fl, s, rs, rt);
        #1;
        checkOutput("dest_sel", destSel, refSel(s));
        if (monitorOn) begin
            checkOutput("hazard_rs", hazardRs, refHaz(rs));
            checkOutput("hazard_rt", hazardRt, refHaz(rt));
        end
        @(posedge clk);
        #1;
        modelStep();
        if (!rn) monitorOn = 1'b1;
    endtask

    task automatic idle(input int n, input int rs, input int rt);
        for (int i = 0; i < n; i++) stepCycle(1, 0, 0, 0, 0, 0, rs, rt);
    endtask

    // Writebacks are popped in arrival order and compared against the queue.
    always @(negedge clk) begin : monitor
        int expDest;
        if (monitorOn) begin
            checkOutput("wb_valid", wbValid, refWbValid());
            if (wbValid === 1'b1) begin
                checkOutput("wb_has_expected", (expQ.size() > 0), 1);
                if (expQ.size() > 0) begin
                    expDest = expQ.pop_front();
                    checkOutput("wb_dest", wbDest, expDest);
                end
            end
        end
    end

    initial begin
        int s, rs, rt;
        for (int k = 0; k < NSEL; k++) slot[k] = k + 1;
        stepCycle(0, 0, 0, 0, 0, 0, 0, 0);
        stepCycle(0, 0, 0, 0, 0, 0, 0, 0);
        idle(1, 0, 0);

        $display("[TB] constant slot 3 writeback");
        stepCycle(1, 1, 1, 0, 0, 3, 0, 0);
        idle(5, 0, 0);

        $display("[TB] hazard tracking on dest 17");
        slot[1] = 17;
        stepCycle(1, 1, 1, 0, 0, 1, 0, 0);
        idle(5, 17, 0);

        $display("[TB] zero destination is untracked");
        slot[0] = 0;
        stepCycle(1, 1, 1, 0, 0, 0, 0, 0);
        idle(5, 0, 0);

        $display("[TB] stall delays dest 8");
        slot[0] = 4;
        slot[1] = 8;
        stepCycle(1, 1, 1, 0, 0, 0, 8, 4);
        stepCycle(1, 1, 1, 0, 0, 1, 8, 4);
        stepCycle(1, 0, 0, 1, 0, 0, 8, 4);
        stepCycle(1, 0, 0, 1, 0, 0, 8, 4);
        idle(6, 8, 4);

        $display("[TB] stall plus flush kills dest 9");
        slot[0] = 12;
        slot[1] = 9;
        stepCycle(1, 1, 1, 0, 0, 0, 9, 12);
        stepCycle(1, 1, 1, 1, 1, 1, 9, 12);
        idle(5, 9, 12);

        $display("[TB] reset mid-flight");
        slot[0] = 5;
        slot[1] = 6;
        slot[4] = 7;
        stepCycle(1, 1, 1, 0, 0, 0, 5, 6);
        stepCycle(1, 1, 1, 0, 0, 1, 5, 6);
        stepCycle(1, 1, 1, 0, 0, 4, 7, 6);
        stepCycle(0, 0, 0, 0, 0, 0, 5, 7);
        idle(4, 5, 7);

        $display("[TB] random traffic");
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) < 3)
                slot[$urandom_range(0, NSEL-1)] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
            s  = $urandom_range(0, NSEL-1);
            rs = ($urandom_range(0, 1) == 1) ? refSel($urandom_range(0, NSEL-1)) : $urandom_range(0, 7);
            rt = ($urandom_range(0, 1) == 1) ? refSel($urandom_range(0, NSEL-1)) : $urandom_range(0, 7);
            stepCycle($urandom_range(0, 99) >= 2,
                      $urandom_range(0, 3) != 0,
                      $urandom_range(0, 4) != 0,
                      $urandom_range(0, 99) < 15,
                      $urandom_range(0, 99) < 10,
                      s, rs, rt);
        end

        idle(STAGES + 2, 0, 0);
        checkOutput("drain_empty", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regdst_pipe.md
Name: regdst_pipe

Overview:
- Parametrised successor to the register-destination selector of the multicycle MIPS datapath.
- Selects the write-destination register number from up to 2^SEL_W sources. Slots 2 and 3 are hard-wired constants (stack pointer, return address).
- Carries each selected destination with a valid bit through a STAGES-deep tracking pipeline that ends at writeback.
- Reports read-after-write hazards for two source operands against in-flight destinations. Supports stall and flush.

Parameters:
- ADDR_W, 5, register-number width
- SEL_W, 3, select width; number of slots NSEL = 2^SEL_W
- STAGES, 3, tracking depth from issue to writeback (minimum 2)
- CONST2, 29, value driven for select slot 2 (sp)
- CONST3, 31, value driven for select slot 3 (ra)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low (0 = reset)
- issue_valid  in  1  an instruction is presented this cycle
- wr_en  in  1  the presented instruction writes a register
- sel  in  SEL_W  destination source select
- src_bus  in  NSEL*ADDR_W  packed candidates, slot k at [k*ADDR_W +: ADDR_W]; slots 2 and 3 ignored
- stall  in  1  hold issue stage
- flush  in  1  kill the issue-stage entry
- rs_addr, rt_addr  in  ADDR_W each  source operands of the presented instruction
- dest_sel  out  ADDR_W  combinational selected destination
- hazard_rs, hazard_rt  out  1 each  operand matches a valid in-flight destination
- wb_valid  out  1  last stage holds a real write
- wb_dest  out  ADDR_W  destination at last stage

Behaviour:
- Reset, synchronous and sampled only at the clk edge while reset=0: all stage valid bits and dest fields clear to 0. wb_valid=0 and wb_dest=0 on the following cycle.
- dest_sel is combinational:
  - slot 2 gives CONST2; slot 3 gives CONST3; any other k gives src_bus slot k.
  - dest_sel is not gated by issue_valid.
- Entry capture into stage 1:
  - entry valid = issue_valid & wr_en & (dest_sel != 0).
  - A destination of $zero is tracked as invalid. It never raises a hazard and never produces a writeback.
- Pipeline: stage[i] to stage[i+1] every cycle. Stage STAGES is the writeback stage, and wb_valid/wb_dest are registered outputs of that stage.
- Priority in stage 1: reset > flush > stall > capture.
  - flush=1: stage 1 loads invalid. Later stages still shift.
  - stall=1 (flush=0): stage 1 holds its contents, stage 2 receives a bubble (valid=0), and stages 3..STAGES shift normally. Entries already past stage 1 always drain.
  - Otherwise: stage 1 captures the new entry.
- Latency: unstalled, an entry issued at edge n appears on wb_* after edge n+STAGES-1 (STAGES cycles of tracking). Each cycle of stall on an entry sitting in stage 1 adds one cycle.
- Hazards are combinational: hazard_rs = OR over stages 1..STAGES of (valid & dest == rs_addr) & (rs_addr != 0). hazard_rt is the same with rt_addr.
  - The writeback stage is included, so no same-cycle write/read bypass is assumed.
  - Hazard outputs do not depend on issue_valid; the consumer qualifies them.
- Simultaneous stall and flush: flush wins; stage 1 becomes invalid.
- Stall held indefinitely: stage 1 is stable, downstream empties within STAGES-1 cycles, and wb_valid goes to 0.
- Reset asserted mid-operation clears all in-flight entries at that edge. No writeback is produced for them.

Decomposition:
- Shared package: ADDR_W default, REG_ZERO=0, REG_SP=29, REG_RA=31, and the select encodings SEL_RT=0, SEL_RD=1, SEL_SP=2, SEL_RA=3.
- One natural sub-module: regdst_stage, a single {valid, dest} register with hold/bubble/load controls, instantiated STAGES times. Hazard comparators stay in the top level.

Test Plan:
- Reset, then sel=3, issue_valid=1, wr_en=1 for one cycle, STAGES=3: dest_sel=31 immediately; wb_valid=1 with wb_dest=31 exactly 3 cycles later, then wb_valid back to 0.
- src_bus slot 1=17, sel=1, issue; next cycle rs_addr=17: hazard_rs=1 while the entry is in stages 1..3, 0 after it leaves. With rt_addr=0 throughout, hazard_rt=0.
- Slot 0=0, sel=0, wr_en=1, issue: stage remains invalid, no hazard for rs_addr=0, no writeback.
- Issue dest 8, then stall=1 for 2 cycles: the dest-8 writeback is delayed by 2 cycles; one bubble per stall cycle appears between it and the preceding entry.
- Issue dest 9 with stall=1 and flush=1 in the same cycle: entry killed, no hazard on 9, no writeback of 9. Older entries still write back on schedule.
- Three back-to-back issues (5, 6, 7), then reset=0 for one edge: all valids clear, and wb_valid stays 0 for the next 4 cycles with no new issue.
